// File: rtl/video_ctrl_pkg.sv
// Shared types and helpers for the video core Avalon control sequencer.
//   seq_state_t : sequencer FSM states
//   DEF_*       : default parameter values
//   idx_width() : counter/index width, $clog2 with a floor of 1
package video_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LATCH = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

  localparam int unsigned DEF_NUM_CORES       = 2;
  localparam int unsigned DEF_ADDR_W          = 1;
  localparam int unsigned DEF_DATA_W          = 32;
  localparam int unsigned DEF_BYPASS_ADDR     = 0;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 50000;
  localparam int unsigned DEF_TIMEOUT_CYCLES  = 256;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/input_debounce.sv
// Two-flop synchroniser followed by a stability filter. The output takes the
// synchronised value only once DEBOUNCE_CYCLES consecutive identical samples
// have been seen.
//   clk, rst : clock, async active-high reset
//   din      : raw asynchronous input vector
//   dout     : debounced vector (RESET_VAL after reset)
module input_debounce
  import video_ctrl_pkg::*;
#(
  parameter int unsigned     DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned     WIDTH           = 1,
  parameter logic [WIDTH-1:0] RESET_VAL      = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  localparam int unsigned      CNT_W    = idx_width(DEBOUNCE_CYCLES);
  // samp plus (cnt+1) further equal samples give DEBOUNCE_CYCLES in a row
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 2);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] samp;
  logic [CNT_W-1:0] cnt;

  // Synchronise, then count how long the synchronised value has been stable
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= RESET_VAL;
      sync2 <= RESET_VAL;
      samp  <= RESET_VAL;
      cnt   <= '0;
      dout  <= RESET_VAL;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      samp  <= sync2;
      if (sync2 != samp) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        dout <= samp;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/video_core_avalon_sequencer.sv
// Writes the debounced bypass switch setting into each video core's bypass
// CSR, one core at a time, on a button press or (optionally) a switch change.
//   sys_clk, sys_rst : clock, async active-high reset
//   core_bypass      : raw bypass switches, bit k for core k
//   avalon_write     : raw push-button, active-low
//   auto_update      : switch changes also start a sequence
//   avs_*            : per-core Avalon-MM write ports (slice k = core k)
//   busy, done, error: status (done is a one-cycle pulse, error is sticky)
module video_core_avalon_sequencer
  import video_ctrl_pkg::*;
#(
  parameter int unsigned NUM_CORES       = DEF_NUM_CORES,
  parameter int unsigned ADDR_W          = DEF_ADDR_W,
  parameter int unsigned DATA_W          = DEF_DATA_W,
  parameter int unsigned BYPASS_ADDR     = DEF_BYPASS_ADDR,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES
) (
  input  logic                        sys_clk,
  input  logic                        sys_rst,
  input  logic [NUM_CORES-1:0]        core_bypass,
  input  logic                        avalon_write,
  input  logic                        auto_update,
  output logic [NUM_CORES*ADDR_W-1:0] avs_address,
  output logic [NUM_CORES-1:0]        avs_write,
  output logic [NUM_CORES*DATA_W-1:0] avs_writedata,
  input  logic [NUM_CORES-1:0]        avs_waitrequest,
  output logic                        busy,
  output logic                        done,
  output logic                        error
);

  localparam int unsigned      IDX_W    = idx_width(NUM_CORES);
  localparam int unsigned      TMR_W    = idx_width(TIMEOUT_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CORES - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  seq_state_t           state;
  logic                 btn_db;
  logic                 btn_prev;
  logic [NUM_CORES-1:0] byp_db;
  logic [NUM_CORES-1:0] byp_prev;
  logic [NUM_CORES-1:0] bypass_q;
  logic [IDX_W-1:0]     idx;
  logic [TMR_W-1:0]     timer;
  logic                 pending;

  logic                 trigger_c;
  logic                 wait_sel_c;
  logic [IDX_W-1:0]     idx_next_c;

  input_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .WIDTH          (1),
    .RESET_VAL      (1'b1)
  ) u_btn_db (
    .clk (sys_clk),
    .rst (sys_rst),
    .din (avalon_write),
    .dout(btn_db)
  );

  input_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .WIDTH          (NUM_CORES),
    .RESET_VAL      ('0)
  ) u_byp_db (
    .clk (sys_clk),
    .rst (sys_rst),
    .din (core_bypass),
    .dout(byp_db)
  );

  // Per-core strobe / address / data vectors with only slice i populated
  function automatic logic [NUM_CORES-1:0] wr_vec(input logic [IDX_W-1:0] i);
    logic [NUM_CORES-1:0] v;
    v = '0;
    for (int unsigned k = 0; k < NUM_CORES; k++) v[k] = (IDX_W'(k) == i);
    return v;
  endfunction

  function automatic logic [NUM_CORES*ADDR_W-1:0] addr_vec(input logic [IDX_W-1:0] i);
    logic [NUM_CORES*ADDR_W-1:0] v;
    v = '0;
    for (int unsigned k = 0; k < NUM_CORES; k++)
      if (IDX_W'(k) == i) v[k*ADDR_W +: ADDR_W] = ADDR_W'(BYPASS_ADDR);
    return v;
  endfunction

  function automatic logic [NUM_CORES*DATA_W-1:0] data_vec(input logic [IDX_W-1:0] i,
                                                           input logic [NUM_CORES-1:0] b);
    logic [NUM_CORES*DATA_W-1:0] v;
    v = '0;
    for (int unsigned k = 0; k < NUM_CORES; k++)
      if (IDX_W'(k) == i) v[k*DATA_W +: DATA_W] = DATA_W'(b[k]);
    return v;
  endfunction

  // Trigger sources merge into one pulse; pick the addressed core's stall
  always_comb begin
    trigger_c  = (btn_prev & ~btn_db) | (auto_update & (byp_db != byp_prev));
    idx_next_c = idx + IDX_W'(1);
    wait_sel_c = 1'b0;
    for (int unsigned k = 0; k < NUM_CORES; k++)
      if (IDX_W'(k) == idx) wait_sel_c = avs_waitrequest[k];
  end

  // Sequencer FSM with registered Avalon and status outputs
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state         <= IDLE;
      btn_prev      <= 1'b1;
      byp_prev      <= '0;
      bypass_q      <= '0;
      idx           <= '0;
      timer         <= '0;
      pending       <= 1'b0;
      avs_write     <= '0;
      avs_address   <= '0;
      avs_writedata <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
    end else begin
      btn_prev <= btn_db;
      byp_prev <= byp_db;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          if (trigger_c) begin
            state <= LATCH;
            busy  <= 1'b1;
          end
        end
        LATCH: begin
          if (trigger_c) pending <= 1'b1;
          bypass_q      <= byp_db;
          idx           <= '0;
          timer         <= '0;
          avs_write     <= wr_vec('0);
          avs_address   <= addr_vec('0);
          avs_writedata <= data_vec('0, byp_db);
          state         <= WRITE;
        end
        WRITE: begin
          if (trigger_c) pending <= 1'b1;
          if (!wait_sel_c || (timer == TMR_LAST)) begin
            // Completed or aborted: both advance to the next core
            if (wait_sel_c) error <= 1'b1;
            timer <= '0;
            if (idx == IDX_LAST) begin
              avs_write     <= '0;
              avs_address   <= '0;
              avs_writedata <= '0;
              done          <= 1'b1;
              state         <= DONE;
            end else begin
              idx           <= idx_next_c;
              avs_write     <= wr_vec(idx_next_c);
              avs_address   <= addr_vec(idx_next_c);
              avs_writedata <= data_vec(idx_next_c, bypass_q);
            end
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        DONE: begin
          // A trigger landing in this very cycle is folded into the rerun too
          pending <= 1'b0;
          if (pending || trigger_c) begin
            state <= LATCH;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_video_core_avalon_sequencer.sv
// Directed self-checking bench for video_core_avalon_sequencer with three
// cores, a short debounce window and an 8-cycle write timeout.
module tb_video_core_avalon_sequencer;

  localparam int unsigned NC = 3;
  localparam int unsigned AW = 2;
  localparam int unsigned DW = 8;
  localparam int unsigned BA = 1;
  localparam int unsigned DB = 4;
  localparam int unsigned TO = 8;

  logic             sys_clk;
  logic             sys_rst;
  logic [NC-1:0]    core_bypass;
  logic             avalon_write;
  logic             auto_update;
  logic [NC*AW-1:0] avs_address;
  logic [NC-1:0]    avs_write;
  logic [NC*DW-1:0] avs_writedata;
  logic [NC-1:0]    avs_waitrequest;
  logic             busy;
  logic             done;
  logic             error;

  int checks   = 0;
  int failures = 0;

  // Slave model: core k stalls the first stall_n[k] cycles of each write
  int unsigned stall_n [NC];
  logic [7:0]  held    [NC];

  // Monitor state, updated from sampled values at each rising edge
  int unsigned cyc = 0;
  int unsigned dcnt = 0;
  int unsigned dcyc = 0;
  int unsigned viol = 0;
  int unsigned wcnt   [NC];
  int unsigned wfirst [NC];
  logic [DW-1:0] wdata [NC];
  logic [NC-1:0] wprev;

  int unsigned base_w [NC];
  int unsigned base_d;

  video_core_avalon_sequencer #(
    .NUM_CORES      (NC),
    .ADDR_W         (AW),
    .DATA_W         (DW),
    .BYPASS_ADDR    (BA),
    .DEBOUNCE_CYCLES(DB),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .sys_clk        (sys_clk),
    .sys_rst        (sys_rst),
    .core_bypass    (core_bypass),
    .avalon_write   (avalon_write),
    .auto_update    (auto_update),
    .avs_address    (avs_address),
    .avs_write      (avs_write),
    .avs_writedata  (avs_writedata),
    .avs_waitrequest(avs_waitrequest),
    .busy           (busy),
    .done           (done),
    .error          (error)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  always_comb begin
    for (int k = 0; k < NC; k++)
      avs_waitrequest[k] = avs_write[k] && (int'(held[k]) < int'(stall_n[k]));
  end

  always @(posedge sys_clk) begin
    for (int k = 0; k < NC; k++)
      held[k] <= avs_write[k] ? held[k] + 8'd1 : 8'd0;
  end

  // More than one strobe, wrong address, or non-zero idle slices
  function automatic bit bus_bad(input logic [NC-1:0] w, input logic [NC*AW-1:0] a,
                                 input logic [NC*DW-1:0] d);
    bit bad;
    bad = ($countones(w) > 1);
    for (int k = 0; k < NC; k++) begin
      if (w[k] && (a[k*AW +: AW] != AW'(BA))) bad = 1'b1;
      if (!w[k] && (a[k*AW +: AW] != '0)) bad = 1'b1;
      if (!w[k] && (d[k*DW +: DW] != '0)) bad = 1'b1;
      if (w[k] && (d[k*DW+1 +: DW-1] != '0)) bad = 1'b1;
    end
    return bad;
  endfunction

  always @(posedge sys_clk) begin
    cyc   <= cyc + 1;
    wprev <= avs_write;
    if (done) begin
      dcnt <= dcnt + 1;
      dcyc <= cyc;
    end
    if (bus_bad(avs_write, avs_address, avs_writedata)) viol <= viol + 1;
    for (int k = 0; k < NC; k++) begin
      if (avs_write[k]) begin
        wcnt[k]  <= wcnt[k] + 1;
        wdata[k] <= avs_writedata[k*DW +: DW];
      end
      if (avs_write[k] && !wprev[k]) wfirst[k] <= cyc;
    end
  end

  task automatic check_val(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic snap();
    for (int k = 0; k < NC; k++) base_w[k] = wcnt[k];
    base_d = dcnt;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int found;
    found = 0;
    for (int i = 0; i < budget && found == 0; i++) begin
      @(negedge sys_clk);
      if (done) found = 1;
    end
    check_val(tag, found, 1);
    @(negedge sys_clk);
  endtask

  task automatic press(input int low, input int high);
    avalon_write = 1'b0;
    repeat (low) @(negedge sys_clk);
    avalon_write = 1'b1;
    repeat (high) @(negedge sys_clk);
  endtask

  initial begin
    sys_rst      = 1'b1;
    core_bypass  = '0;
    avalon_write = 1'b1;
    auto_update  = 1'b0;
    for (int k = 0; k < NC; k++) begin
      stall_n[k] = 0;
      wcnt[k]    = 0;
      wfirst[k]  = 0;
      wdata[k]   = '0;
    end
    wprev = '0;
    repeat (3) @(negedge sys_clk);

    // Reset state
    check_val("rst_write", int'(avs_write), 0);
    check_val("rst_addr", int'(avs_address), 0);
    check_val("rst_data", int'(avs_writedata), 0);
    check_val("rst_busy", int'(busy), 0);
    check_val("rst_done", int'(done), 0);
    check_val("rst_error", int'(error), 0);
    sys_rst = 1'b0;

    // Switch change with auto_update off must not start a sequence
    core_bypass = 3'b010;
    repeat (15) @(negedge sys_clk);
    check_val("noauto_writes", int'(wcnt[0] + wcnt[1] + wcnt[2]), 0);

    // One press, no stalls: cores on consecutive cycles, done right after
    snap();
    avalon_write = 1'b0;
    wait_done("a_done_seen", 40);
    avalon_write = 1'b1;
    check_val("a_w0_len", int'(wcnt[0] - base_w[0]), 1);
    check_val("a_w1_len", int'(wcnt[1] - base_w[1]), 1);
    check_val("a_w2_len", int'(wcnt[2] - base_w[2]), 1);
    check_val("a_d0", int'(wdata[0]), 0);
    check_val("a_d1", int'(wdata[1]), 1);
    check_val("a_d2", int'(wdata[2]), 0);
    check_val("a_w1_cyc", int'(wfirst[1] - wfirst[0]), 1);
    check_val("a_w2_cyc", int'(wfirst[2] - wfirst[0]), 2);
    check_val("a_done_cyc", int'(dcyc - wfirst[0]), 3);
    check_val("a_done_cnt", int'(dcnt - base_d), 1);
    check_val("a_busy", int'(busy), 0);
    check_val("a_error", int'(error), 0);
    repeat (10) @(negedge sys_clk);

    // Three-cycle button glitch is filtered out
    snap();
    press(3, 20);
    check_val("glitch_writes", int'(wcnt[0] - base_w[0]), 0);
    check_val("glitch_done", int'(dcnt - base_d), 0);

    // Core 1 stalls three cycles: its write lasts four, later events slip by three
    stall_n[1] = 3;
    snap();
    avalon_write = 1'b0;
    wait_done("s_done_seen", 50);
    avalon_write = 1'b1;
    check_val("s_w0_len", int'(wcnt[0] - base_w[0]), 1);
    check_val("s_w1_len", int'(wcnt[1] - base_w[1]), 4);
    check_val("s_w2_len", int'(wcnt[2] - base_w[2]), 1);
    check_val("s_w2_cyc", int'(wfirst[2] - wfirst[0]), 5);
    check_val("s_done_cyc", int'(dcyc - wfirst[0]), 6);
    check_val("s_error", int'(error), 0);
    stall_n[1] = 0;
    repeat (10) @(negedge sys_clk);

    // Core 0 stuck: write held for the full timeout, error set, rest still written
    stall_n[0] = 255;
    snap();
    avalon_write = 1'b0;
    wait_done("t_done_seen", 60);
    avalon_write = 1'b1;
    check_val("t_w0_len", int'(wcnt[0] - base_w[0]), 8);
    check_val("t_w1_len", int'(wcnt[1] - base_w[1]), 1);
    check_val("t_w2_len", int'(wcnt[2] - base_w[2]), 1);
    check_val("t_w1_cyc", int'(wfirst[1] - wfirst[0]), 8);
    check_val("t_done_cyc", int'(dcyc - wfirst[0]), 10);
    check_val("t_error", int'(error), 1);
    repeat (10) @(negedge sys_clk);

    // Two extra presses during a long sequence coalesce into one rerun
    for (int k = 0; k < NC; k++) stall_n[k] = 255;
    snap();
    press(5, 5);
    press(5, 5);
    press(5, 5);
    repeat (100) @(negedge sys_clk);
    check_val("p_done_cnt", int'(dcnt - base_d), 2);
    check_val("p_w0_len", int'(wcnt[0] - base_w[0]), 16);
    check_val("p_busy", int'(busy), 0);
    check_val("p_error_sticky", int'(error), 1);
    for (int k = 0; k < NC; k++) stall_n[k] = 0;

    // auto_update: a switch change alone starts a sequence
    auto_update = 1'b1;
    snap();
    core_bypass = 3'b011;
    wait_done("u_done_seen", 40);
    check_val("u_d0", int'(wdata[0]), 1);
    check_val("u_d1", int'(wdata[1]), 1);
    check_val("u_d2", int'(wdata[2]), 0);
    check_val("u_done_cnt", int'(dcnt - base_d), 1);
    repeat (5) @(negedge sys_clk);

    // Reset during a write: outputs clear at once, no completion follows
    stall_n[0]  = 255;
    core_bypass = 3'b111;
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 40 && seen == 0; i++) begin
        @(negedge sys_clk);
        if (avs_write[0]) seen = 1;
      end
      check_val("r_write_seen", seen, 1);
    end
    snap();
    sys_rst = 1'b1;
    #1;
    check_val("r_write", int'(avs_write), 0);
    check_val("r_addr", int'(avs_address), 0);
    check_val("r_data", int'(avs_writedata), 0);
    check_val("r_busy", int'(busy), 0);
    check_val("r_error", int'(error), 0);
    auto_update = 1'b0;
    stall_n[0]  = 0;
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b0;
    repeat (30) @(negedge sys_clk);
    check_val("r_done_cnt", int'(dcnt - base_d), 0);
    check_val("r_w1_len", int'(wcnt[1] - base_w[1]), 0);
    check_val("r_done", int'(done), 0);

    check_val("bus_violations", int'(viol), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
